// File: rtl/gshare_pkg.sv
// Shared constants, FSM state type and table-init helper for the gshare predictor.
package gshare_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int init_cnt_val(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/gshare_bht.sv
// Branch history table of saturating counters: asynchronous reads for the
// prediction and update indices, one synchronous write (init beats update).
module gshare_bht #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] pred_idx,
    output logic [CNT_W-1:0] pred_cnt,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [CNT_W-1:0] upd_cnt,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_idx,
    input  logic [CNT_W-1:0] init_data,
    input  logic             upd_we,
    input  logic [CNT_W-1:0] upd_data
);

    logic [CNT_W-1:0] mem [2**IDX_W];

    assign pred_cnt = mem[pred_idx];
    assign upd_cnt  = mem[upd_idx];

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end else if (upd_we) begin
            mem[upd_idx] <= upd_data;
        end
    end

endmodule

// File: rtl/gshare_bp.sv
// gshare predictor top: table-init FSM, speculative history with repair,
// saturating counter update and saturating statistics.
//   state   | meaning
//   ST_INIT | writing INIT_CNT to every entry, one per clock; predictor idle
//   ST_RUN  | predictions and updates live
module gshare_bp
    import gshare_pkg::*;
#(
    parameter int GHR_W  = 8,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 2,
    parameter int PC_LSB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic [31:0]      pred_pc,
    input  logic [6:0]       pred_opcode,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    output logic             ready,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic [31:0]      stat_updates,
    output logic [31:0]      stat_mispredicts
);

    localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(init_cnt_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [IDX_W-1:0] init_idx;
    logic [GHR_W-1:0] sghr;

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [CNT_W-1:0] pred_cnt;
    logic [CNT_W-1:0] upd_cnt;
    logic [CNT_W-1:0] upd_next;
    logic             init_we;
    logic             upd_acc;

    // Only pc[PC_LSB +: IDX_W] takes part in the index.
    logic [63:0] unused_pc;
    assign unused_pc = {pred_pc, upd_pc};

    assign ready    = (state == ST_RUN);
    assign pred_ghr = sghr;
    assign pred_idx = pred_pc[PC_LSB +: IDX_W] ^ IDX_W'(sghr);
    assign upd_idx  = upd_pc[PC_LSB +: IDX_W] ^ IDX_W'(upd_ghr);
    assign init_we  = (state == ST_INIT) && !rst;
    assign upd_acc  = ready && upd_valid && !rst;

    always_comb begin
        pred_taken = 1'b0;
        if (ready) begin
            if (pred_opcode == OP_JAL || pred_opcode == OP_JALR) begin
                pred_taken = 1'b1;
            end else if (pred_opcode == OP_BRANCH) begin
                pred_taken = pred_cnt[CNT_W-1];
            end
        end
    end

    always_comb begin
        upd_next = upd_cnt;
        if (upd_taken) begin
            if (upd_cnt != CNT_MAX) upd_next = upd_cnt + CNT_W'(1);
        end else begin
            if (upd_cnt != '0) upd_next = upd_cnt - CNT_W'(1);
        end
    end

    gshare_bht #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) u_bht (
        .clk       (clk),
        .pred_idx  (pred_idx),
        .pred_cnt  (pred_cnt),
        .upd_idx   (upd_idx),
        .upd_cnt   (upd_cnt),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_data (INIT_CNT),
        .upd_we    (upd_acc),
        .upd_data  (upd_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + IDX_W'(1);
            if (init_idx == '1) state <= ST_RUN;
        end
    end

    // A mispredict repair wins over the speculative shift of the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sghr <= '0;
        end else if (ready) begin
            if (upd_valid && upd_mispredict) begin
                sghr <= {upd_ghr[GHR_W-2:0], upd_taken};
            end else if (pred_valid && pred_opcode == OP_BRANCH) begin
                sghr <= {sghr[GHR_W-2:0], pred_taken};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else if (upd_acc) begin
            if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
            if (upd_mispredict && stat_mispredicts != '1) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp: init timing, vector table of opcode/PC
// predictions, counter saturation, history shift/repair and reset restart.
module tb_gshare_bp;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic [6:0]  pred_opcode;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        ready;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gshare_bp dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_opcode      (pred_opcode),
        .pred_taken       (pred_taken),
        .pred_ghr         (pred_ghr),
        .ready            (ready),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_ghr          (upd_ghr),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_updates     (stat_updates),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [6:0]  op;
        logic        exp_taken;
        logic [7:0]  exp_ghr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid     = 1'b0;
        pred_pc        = '0;
        pred_opcode    = '0;
        upd_valid      = 1'b0;
        upd_pc         = '0;
        upd_ghr        = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic [7:0] ghr, input logic taken);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_ghr        = ghr;
        upd_taken      = taken;
        upd_mispredict = 1'b0;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic chk_pred(input string name, input logic [31:0] pc, input logic [6:0] op,
                            input logic exp);
        pred_valid  = 1'b0;
        pred_pc     = pc;
        pred_opcode = op;
        #1;
        chk(name, 32'(pred_taken), 32'(exp));
    endtask

    initial begin
        vecs[0] = '{"br_pc0",    32'h0000_0000, BR,   1'b0, 8'h00};
        vecs[1] = '{"br_pc40",   32'h0000_0040, BR,   1'b0, 8'h00};
        vecs[2] = '{"br_pc3fc",  32'h0000_03FC, BR,   1'b0, 8'h00};
        vecs[3] = '{"jal",       32'h0000_0040, JAL,  1'b1, 8'h00};
        vecs[4] = '{"jalr",      32'h0000_0123, JALR, 1'b1, 8'h00};
        vecs[5] = '{"alu",       32'h0000_0040, ALU,  1'b0, 8'h00};
        vecs[6] = '{"br_pchigh", 32'hFFFF_FFFC, BR,   1'b0, 8'h00};

        idle();
        rst         = 1'b1;
        pred_opcode = JAL;
        step();
        #1;
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_ghr", 32'(pred_ghr), 32'd0);
        chk("rst_stat_upd", stat_updates, 32'd0);
        chk("rst_stat_misp", stat_mispredicts, 32'd0);
        rst = 1'b0;
        idle();

        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 255) chk("init_ready_255", 32'(ready), 32'd0);
            if (i == 256) chk("init_ready_256", 32'(ready), 32'd1);
        end

        // Vector table: every counter is weakly not-taken, sghr stays 0.
        for (int v = 0; v < 7; v++) begin
            pred_valid  = 1'b1;
            pred_pc     = vecs[v].pc;
            pred_opcode = vecs[v].op;
            #1;
            chk({vecs[v].name, "_taken"}, 32'(pred_taken), 32'(vecs[v].exp_taken));
            step();
            chk({vecs[v].name, "_ghr"}, 32'(pred_ghr), 32'(vecs[v].exp_ghr));
        end
        idle();

        // Saturation on index 0x10 (pc 0x40, ghr 0).
        do_upd(32'h40, 8'h00, 1'b1);
        do_upd(32'h40, 8'h00, 1'b1);
        chk_pred("sat_t2", 32'h40, BR, 1'b1);
        do_upd(32'h40, 8'h00, 1'b1);
        do_upd(32'h40, 8'h00, 1'b1);
        chk_pred("sat_t4", 32'h40, BR, 1'b1);
        do_upd(32'h40, 8'h00, 1'b0);
        chk_pred("sat_nt1", 32'h40, BR, 1'b1);
        do_upd(32'h40, 8'h00, 1'b0);
        chk_pred("sat_nt2", 32'h40, BR, 1'b0);
        do_upd(32'h40, 8'h00, 1'b0);
        do_upd(32'h40, 8'h00, 1'b0);
        do_upd(32'h40, 8'h00, 1'b0);
        chk_pred("jal_cnt0", 32'h40, JAL, 1'b1);
        do_upd(32'h40, 8'h00, 1'b1);
        chk_pred("sat0_t1", 32'h40, BR, 1'b0);
        do_upd(32'h40, 8'h00, 1'b1);
        chk_pred("sat0_t2", 32'h40, BR, 1'b1);
        chk("stat_upd_11", stat_updates, 32'd11);
        chk("stat_misp_0", stat_mispredicts, 32'd0);
        chk("ghr_after_upd", 32'(pred_ghr), 32'd0);

        // Speculative shift 0,1,1 then repair in the same cycle as a query.
        pred_valid = 1'b1; pred_pc = 32'h0; pred_opcode = BR; #1;
        chk("sh1_taken", 32'(pred_taken), 32'd0);
        step();
        chk("sh1_ghr", 32'(pred_ghr), 32'd0);
        pred_pc = 32'h40; #1;
        chk("sh2_taken", 32'(pred_taken), 32'd1);
        step();
        chk("sh2_ghr", 32'(pred_ghr), 32'd1);
        pred_pc = 32'h44; #1;
        chk("sh3_taken", 32'(pred_taken), 32'd1);
        step();
        chk("sh3_ghr", 32'(pred_ghr), 32'd3);
        pred_pc        = 32'h40;
        upd_valid      = 1'b1;
        upd_pc         = 32'h100;
        upd_ghr        = 8'h01;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b1;
        #1;
        chk("rep_pred", 32'(pred_taken), 32'd0);
        step();
        idle();
        chk("rep_ghr", 32'(pred_ghr), 32'd2);
        chk("rep_stat_upd", stat_updates, 32'd12);
        chk("rep_stat_misp", stat_mispredicts, 32'd1);

        // Same-cycle query and update at index 0x82 (counter 01).
        pred_valid     = 1'b1;
        pred_pc        = 32'h200;
        pred_opcode    = BR;
        upd_valid      = 1'b1;
        upd_pc         = 32'h200;
        upd_ghr        = 8'h02;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b0;
        #1;
        chk("rbw_same", 32'(pred_taken), 32'd0);
        step();
        idle();
        chk("rbw_ghr", 32'(pred_ghr), 32'd4);
        chk_pred("rbw_next", 32'h218, BR, 1'b1);
        chk("rbw_stat_upd", stat_updates, 32'd13);
        chk("rbw_stat_misp", stat_mispredicts, 32'd1);

        // Reset during RUN, again at init index 100, with traffic during INIT.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_ready", 32'(ready), 32'd0);
        chk("rst2_ghr", 32'(pred_ghr), 32'd0);
        for (int i = 1; i <= 100; i++) step();
        rst = 1'b1;
        step();
        rst            = 1'b0;
        pred_valid     = 1'b1;
        pred_pc        = 32'h40;
        pred_opcode    = JAL;
        upd_valid      = 1'b1;
        upd_pc         = 32'h40;
        upd_ghr        = 8'hFF;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 255) begin
                chk("rst3_ready_255", 32'(ready), 32'd0);
                chk("rst3_pred_taken", 32'(pred_taken), 32'd0);
                chk("rst3_ghr", 32'(pred_ghr), 32'd0);
                chk("rst3_stat_upd", stat_updates, 32'd0);
                chk("rst3_stat_misp", stat_mispredicts, 32'd0);
            end
            if (i == 256) begin
                idle();
                chk("rst3_ready_256", 32'(ready), 32'd1);
            end
        end
        step();
        chk("rst3_stat_upd_run", stat_updates, 32'd0);
        chk("rst3_stat_misp_run", stat_mispredicts, 32'd0);
        chk("rst3_ghr_run", 32'(pred_ghr), 32'd0);
        chk_pred("rst3_reinit_40", 32'h40, BR, 1'b0);
        chk_pred("rst3_reinit_44", 32'h44, BR, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
